// File: rtl/rtc_multi_alarm.sv
// rtc_multi_alarm
//   BCD real-time-clock core with NUM_ALARMS programmable alarm slots,
//   12/24-hour display conversion and an auto-stopping ring.
//   Time is held internally in 24-hour BCD; the 12-hour view is applied
//   to the outputs only.
//
// Optional feature macro: RTC_SNOOZE_EN (snooze state and SNOOZE_SEC timer).
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   set_load, set_time  1-cycle strobe loading a 24-bit BCD hh:mm:ss time
//   mode_12h            1 selects the 12-hour display
//   alarm_wr, alarm_idx,
//   alarm_time          1-cycle strobe writing a BCD hh:mm into one slot
//   alarm_en            per-slot enable
//   alarm_ack           stop ringing
//   snooze              snooze request (used only with RTC_SNOOZE_EN)
//   time_bcd, pm        displayed time and the afternoon flag
//   sec_pulse           1-cycle pulse on each seconds advance
//   set_err             1-cycle pulse when a load or slot write is rejected
//   alarm_ring          buzzer drive
//   alarm_hit           slots responsible for the current ring
//
// FSM states
//   IDLE   | no alarm active
//   RING   | buzzer on, counting seconds toward RING_SEC
//   SNOOZE | buzzer off, hit slots held, counting toward SNOOZE_SEC

module rtc_multi_alarm #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int NUM_ALARMS = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  localparam int IDX_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_load,
  input  logic [23:0]           set_time,
  input  logic                  mode_12h,
  input  logic                  alarm_wr,
  input  logic [IDX_W-1:0]      alarm_idx,
  input  logic [15:0]           alarm_time,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  alarm_ack,
  input  logic                  snooze,
  output logic [23:0]           time_bcd,
  output logic                  pm,
  output logic                  sec_pulse,
  output logic                  set_err,
  output logic                  alarm_ring,
  output logic [NUM_ALARMS-1:0] alarm_hit
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [15:0]   RING_LIM   = 16'(RING_SEC);
  localparam logic [15:0]   SNOOZE_LIM = 16'(SNOOZE_SEC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  logic [PW-1:0]  presc;
  logic [23:0]    cur_time;
  logic [23:0]    time_inc;
  logic [15:0]    slot [NUM_ALARMS];
  logic           presc_wrap;
  logic           tick;
  logic           load_ok;
  logic           wr_ok;
  logic           idx_ok;
  logic [NUM_ALARMS-1:0] match;
  logic           snooze_req;

  state_t                state, state_nxt;
  logic [NUM_ALARMS-1:0] hit_nxt;
  logic [15:0]           cnt, cnt_nxt;

  // hh:mm validity: digits <= 9, minute tens <= 5, hour <= 23
  function automatic logic hm_ok(input logic [15:0] t);
    logic hour_ok;
    hour_ok = ((t[15:12] < 4'd2) && (t[11:8] <= 4'd9)) ||
              ((t[15:12] == 4'd2) && (t[11:8] <= 4'd3));
    return hour_ok && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  function automatic logic time_ok(input logic [23:0] t);
    return hm_ok(t[23:8]) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  `ifdef RTC_SNOOZE_EN
  assign snooze_req = snooze;
  `else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snooze_req    = 1'b0;
  `endif

  assign presc_wrap = (presc == PRESC_MAX);
  // a load strobe (valid or not) owns the cycle, so the tick waits
  assign tick       = !set_load && presc_wrap;
  assign load_ok    = time_ok(set_time);
  assign idx_ok     = ({{(32-IDX_W){1'b0}}, alarm_idx} < 32'(NUM_ALARMS));
  assign wr_ok      = hm_ok(alarm_time) && idx_ok;

  // Full one-second carry chain, resolved combinationally
  always_comb begin
    logic [3:0] hs, hg, ms, mg, ts, tg;
    {hs, hg, ms, mg, ts, tg} = cur_time;
    if (tg != 4'd9) begin
      tg = tg + 4'd1;
    end else begin
      tg = 4'd0;
      if (ts != 4'd5) begin
        ts = ts + 4'd1;
      end else begin
        ts = 4'd0;
        if (mg != 4'd9) begin
          mg = mg + 4'd1;
        end else begin
          mg = 4'd0;
          if (ms != 4'd5) begin
            ms = ms + 4'd1;
          end else begin
            ms = 4'd0;
            if ((hs == 4'd2) && (hg == 4'd3)) begin
              hs = 4'd0;
              hg = 4'd0;
            end else if (hg == 4'd9) begin
              hg = 4'd0;
              hs = hs + 4'd1;
            end else begin
              hg = hg + 4'd1;
            end
          end
        end
      end
    end
    time_inc = {hs, hg, ms, mg, ts, tg};
  end

  // Matches only on a tick landing on ss=00, compared against pre-write slots
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = tick && (time_inc[7:0] == 8'h00) && alarm_en[i] &&
                 (slot[i] == time_inc[23:8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc     <= '0;
      cur_time  <= '0;
      sec_pulse <= 1'b0;
      set_err   <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot[i] <= '0;
      end
    end else begin
      sec_pulse <= 1'b0;
      set_err   <= (set_load && !load_ok) || (alarm_wr && !wr_ok);
      if (set_load) begin
        if (load_ok) begin
          cur_time <= set_time;
          presc    <= '0;
        end
      end else if (presc_wrap) begin
        presc     <= '0;
        cur_time  <= time_inc;
        sec_pulse <= 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (alarm_wr && wr_ok) begin
        slot[alarm_idx] <= alarm_time;
      end
    end
  end

  // Display conversion
  always_comb begin
    logic [4:0] hour_bin;
    logic [4:0] disp_hour;
    logic [3:0] tens;
    logic [4:0] ones;
    hour_bin = ({1'b0, cur_time[23:20]} * 5'd10) + {1'b0, cur_time[19:16]};
    pm       = (hour_bin >= 5'd12);
    disp_hour = hour_bin;
    if (mode_12h) begin
      if (hour_bin == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_bin > 5'd12) begin
        disp_hour = hour_bin - 5'd12;
      end
    end
    if (disp_hour >= 5'd20) begin
      tens = 4'd2;
      ones = disp_hour - 5'd20;
    end else if (disp_hour >= 5'd10) begin
      tens = 4'd1;
      ones = disp_hour - 5'd10;
    end else begin
      tens = 4'd0;
      ones = disp_hour;
    end
    time_bcd = {tens, ones[3:0], cur_time[15:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      alarm_hit <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      alarm_hit <= hit_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // A fresh match always wins: it restarts the count even over ack or snooze
  always_comb begin
    state_nxt  = state;
    hit_nxt    = alarm_hit;
    cnt_nxt    = cnt;
    alarm_ring = (state == RING);
    case (state)
      IDLE: begin
        if (|match) begin
          state_nxt = RING;
          hit_nxt   = match;
          cnt_nxt   = '0;
        end
      end
      RING: begin
        if (|match) begin
          hit_nxt = alarm_hit | match;
          cnt_nxt = '0;
        end else if (alarm_ack) begin
          state_nxt = IDLE;
          hit_nxt   = '0;
          cnt_nxt   = '0;
        end else if (snooze_req) begin
          state_nxt = SNOOZE;
          cnt_nxt   = '0;
        end else if ((alarm_hit & alarm_en) == '0) begin
          state_nxt = IDLE;
          hit_nxt   = '0;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt + 16'd1 >= RING_LIM) begin
            state_nxt = IDLE;
            hit_nxt   = '0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      SNOOZE: begin
        if (|match) begin
          state_nxt = RING;
          hit_nxt   = alarm_hit | match;
          cnt_nxt   = '0;
        end else if (alarm_ack) begin
          state_nxt = IDLE;
          hit_nxt   = '0;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt + 16'd1 >= SNOOZE_LIM) begin
            state_nxt = RING;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        hit_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rtc_multi_alarm.sv
// tb_rtc_multi_alarm
//   Self-checking bench for rtc_multi_alarm. A reference model keeps time as
//   seconds-of-day and alarms as minutes-of-day; every cycle all outputs are
//   compared against it, with directed scenarios followed by random traffic.
//   Define RTC_SNOOZE_EN for both files to exercise the snooze path.

module tb_rtc_multi_alarm;

  localparam int TICK_DIV   = 4;
  localparam int NUM_ALARMS = 4;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_load = 1'b0;
  logic [23:0] set_time = '0;
  logic        mode_12h = 1'b0;
  logic        alarm_wr = 1'b0;
  logic [1:0]  alarm_idx = '0;
  logic [15:0] alarm_time = '0;
  logic [3:0]  alarm_en = '0;
  logic        alarm_ack = 1'b0;
  logic        snooze = 1'b0;
  logic [23:0] time_bcd;
  logic        pm;
  logic        sec_pulse;
  logic        set_err;
  logic        alarm_ring;
  logic [3:0]  alarm_hit;

  rtc_multi_alarm #(
    .TICK_DIV(TICK_DIV), .NUM_ALARMS(NUM_ALARMS),
    .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .set_load(set_load), .set_time(set_time),
    .mode_12h(mode_12h), .alarm_wr(alarm_wr), .alarm_idx(alarm_idx),
    .alarm_time(alarm_time), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .snooze(snooze), .time_bcd(time_bcd), .pm(pm), .sec_pulse(sec_pulse),
    .set_err(set_err), .alarm_ring(alarm_ring), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int       m_sec, m_pre, m_cnt;
  int       m_alarm [NUM_ALARMS];
  bit       m_ring, m_snz, m_sp, m_err;
  bit [3:0] m_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hm_valid(input logic [15:0] t);
    int h;
    h = int'(t[15:12]) * 10 + int'(t[11:8]);
    return (t[15:12] <= 9) && (t[11:8] <= 9) && (h <= 23) &&
           (t[7:4] <= 5) && (t[3:0] <= 9);
  endfunction

  function automatic bit t_valid(input logic [23:0] t);
    return hm_valid(t[23:8]) && (t[7:4] <= 5) && (t[3:0] <= 9);
  endfunction

  function automatic int bcd_to_sec(input logic [23:0] t);
    return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
           (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic int hm_to_min(input logic [15:0] t);
    return (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic [23:0] sec_to_bcd(input int s, input bit m12);
    int h, mi, se;
    h  = s / 3600;
    mi = (s / 60) % 60;
    se = s % 60;
    if (m12) begin
      if (h == 0) h = 12;
      else if (h > 12) h = h - 12;
    end
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  function automatic logic [15:0] min_to_hm(input int m);
    logic [23:0] b;
    b = sec_to_bcd(m * 60, 1'b0);
    return b[23:8];
  endfunction

  task automatic model_step();
    bit       tick;
    bit [3:0] match;
    m_sp  = 0;
    m_err = 0;
    if (!rst_n) begin
      m_sec = 0; m_pre = 0; m_cnt = 0;
      m_ring = 0; m_snz = 0; m_hit = '0;
      for (int i = 0; i < NUM_ALARMS; i++) m_alarm[i] = 0;
      return;
    end
    tick = 0;
    if (set_load) begin
      if (t_valid(set_time)) begin
        m_sec = bcd_to_sec(set_time);
        m_pre = 0;
      end else begin
        m_err = 1;
      end
    end else if (m_pre == TICK_DIV - 1) begin
      m_pre = 0;
      tick  = 1;
      m_sec = (m_sec + 1) % 86400;
      m_sp  = 1;
    end else begin
      m_pre++;
    end
    match = '0;
    if (tick && (m_sec % 60 == 0))
      for (int i = 0; i < NUM_ALARMS; i++)
        if (alarm_en[i] && m_alarm[i] == m_sec / 60) match[i] = 1;
    if (alarm_wr) begin
      if (hm_valid(alarm_time) && int'(alarm_idx) < NUM_ALARMS)
        m_alarm[alarm_idx] = hm_to_min(alarm_time);
      else
        m_err = 1;
    end
    if (match != 0) begin
      m_ring = 1; m_snz = 0; m_hit = m_hit | match; m_cnt = 0;
    end else if (m_ring) begin
      if (alarm_ack) begin
        m_ring = 0; m_hit = '0;
      end
`ifdef RTC_SNOOZE_EN
      else if (snooze) begin
        m_ring = 0; m_snz = 1; m_cnt = 0;
      end
`endif
      else if ((m_hit & alarm_en) == 0) begin
        m_ring = 0; m_hit = '0;
      end else if (tick) begin
        m_cnt++;
        if (m_cnt >= RING_SEC) begin
          m_ring = 0; m_hit = '0;
        end
      end
    end else if (m_snz) begin
      if (alarm_ack) begin
        m_snz = 0; m_hit = '0;
      end else if (tick) begin
        m_cnt++;
        if (m_cnt >= SNOOZE_SEC) begin
          m_snz = 0; m_ring = 1; m_cnt = 0;
        end
      end
    end
  endtask

  // one clock: model advances with the DUT, outputs compared on the falling edge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("time_bcd", 32'(time_bcd), 32'(sec_to_bcd(m_sec, mode_12h)));
    check("pm", 32'(pm), 32'(m_sec >= 12 * 3600));
    check("sec_pulse", 32'(sec_pulse), 32'(m_sp));
    check("set_err", 32'(set_err), 32'(m_err));
    check("alarm_ring", 32'(alarm_ring), 32'(m_ring));
    check("alarm_hit", 32'(alarm_hit), 32'(m_hit));
  endtask

  task automatic do_load(input logic [23:0] t);
    set_load = 1'b1;
    set_time = t;
    cyc();
    set_load = 1'b0;
  endtask

  task automatic do_wr(input logic [1:0] idx, input logic [15:0] t);
    alarm_wr   = 1'b1;
    alarm_idx  = idx;
    alarm_time = t;
    cyc();
    alarm_wr = 1'b0;
  endtask

  task automatic wait_pulses(input int n);
    int seen = 0;
    for (int i = 0; i < n * TICK_DIV + 8 && seen < n; i++) begin
      cyc();
      if (sec_pulse) seen++;
    end
    check("pulse_wait", 32'(seen), 32'(n));
  endtask

  int pulses;
  int r;

  initial begin
    // reset
    rst_n = 1'b0;
    cyc();
    cyc();
    check("rst_time", 32'(time_bcd), 32'h0);
    check("rst_ring", 32'(alarm_ring), 32'h0);
    rst_n = 1'b1;

    pulses = 0;
    for (int i = 0; i < TICK_DIV; i++) begin
      cyc();
      if (sec_pulse) pulses++;
    end
    check("first_sec_pulses", 32'(pulses), 32'd1);
    check("first_sec_time", 32'(time_bcd), 32'h000001);

    do_load(24'h235959);
    check("load_no_err", 32'(set_err), 32'h0);
    wait_pulses(1);
    check("midnight_wrap", 32'(time_bcd), 32'h000000);

    mode_12h = 1'b1;
    do_load(24'h123456);
    check("h12_noon", 32'(time_bcd), 32'h123456);
    check("h12_noon_pm", 32'(pm), 32'h1);
    do_load(24'h001000);
    check("h12_midnight", 32'(time_bcd), 32'h121000);
    check("h12_midnight_pm", 32'(pm), 32'h0);
    do_load(24'h130000);
    check("h12_13h", 32'(time_bcd), 32'h010000);
    check("h12_13h_pm", 32'(pm), 32'h1);
    mode_12h = 1'b0;

    do_load(24'h240000);
    check("bad_hour_err", 32'(set_err), 32'h1);
    check("bad_hour_keep", 32'(time_bcd), 32'h130000);
    do_load(24'h096000);
    check("bad_min_err", 32'(set_err), 32'h1);
    do_load(24'h0A0000);
    check("bad_digit_err", 32'(set_err), 32'h1);
    cyc();
    check("err_one_cycle", 32'(set_err), 32'h0);
    do_wr(2'd0, 16'h2400);
    check("bad_alarm_err", 32'(set_err), 32'h1);

    // single slot ring and timeout
    alarm_en = 4'b0100;
    do_wr(2'd2, 16'h0700);
    do_load(24'h065959);
    wait_pulses(1);
    check("ring_on", 32'(alarm_ring), 32'h1);
    check("ring_hit", 32'(alarm_hit), 32'h4);
    wait_pulses(RING_SEC);
    check("ring_timeout", 32'(alarm_ring), 32'h0);
    check("ring_timeout_hit", 32'(alarm_hit), 32'h0);

    // acknowledge
    do_load(24'h065959);
    wait_pulses(1);
    check("ring_again", 32'(alarm_ring), 32'h1);
    alarm_ack = 1'b1;
    cyc();
    alarm_ack = 1'b0;
    check("ack_stops", 32'(alarm_ring), 32'h0);

    // two equal slots
    do_wr(2'd0, 16'h0800);
    do_wr(2'd1, 16'h0800);
    alarm_en = 4'b0011;
    do_load(24'h075959);
    wait_pulses(1);
    check("dual_hit", 32'(alarm_hit), 32'h3);
    alarm_ack = 1'b1;
    cyc();
    alarm_ack = 1'b0;

    // direct load onto the alarm minute never rings
    alarm_en = 4'b0100;
    do_load(24'h070000);
    for (int i = 0; i < 2 * TICK_DIV; i++) cyc();
    check("load_no_ring", 32'(alarm_ring), 32'h0);

`ifdef RTC_SNOOZE_EN
    do_load(24'h065959);
    wait_pulses(1);
    check("snz_ring", 32'(alarm_ring), 32'h1);
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    check("snz_quiet", 32'(alarm_ring), 32'h0);
    wait_pulses(SNOOZE_SEC);
    check("snz_resume", 32'(alarm_ring), 32'h1);
    check("snz_hit_held", 32'(alarm_hit), 32'h4);
    alarm_ack = 1'b1;
    cyc();
    alarm_ack = 1'b0;
    check("snz_ack", 32'(alarm_ring), 32'h0);
`endif

    // random traffic
    alarm_en = 4'b1111;
    for (int i = 0; i < NUM_ALARMS; i++)
      do_wr(2'(i), min_to_hm($urandom_range(0, 1439)));
    for (int n = 0; n < 5000; n++) begin
      set_load  = 1'b0;
      alarm_wr  = 1'b0;
      alarm_ack = 1'b0;
      snooze    = 1'b0;
      rst_n     = ($urandom_range(0, 999) != 0);
      r = $urandom_range(0, 99);
      if (r < 3) begin
        set_load = 1'b1;
        set_time = sec_to_bcd((m_alarm[$urandom_range(0, 3)] * 60 -
                               $urandom_range(1, 4) + 86400) % 86400, 1'b0);
      end else if (r < 5) begin
        set_load = 1'b1;
        set_time = 24'($urandom());
      end
      r = $urandom_range(0, 99);
      if (r < 2) begin
        alarm_wr   = 1'b1;
        alarm_idx  = 2'($urandom_range(0, 3));
        alarm_time = min_to_hm($urandom_range(0, 1439));
      end else if (r < 3) begin
        alarm_wr   = 1'b1;
        alarm_idx  = 2'($urandom_range(0, 3));
        alarm_time = 16'($urandom());
      end
      if ($urandom_range(0, 99) < 2) alarm_ack = 1'b1;
      if ($urandom_range(0, 99) < 3) snooze = 1'b1;
      if ($urandom_range(0, 99) < 4) mode_12h = ~mode_12h;
      if ($urandom_range(0, 199) == 0) alarm_en = 4'($urandom());
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
